// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} tRxState;
    localparam int WORD36 = 36;
endpackage

// File: rtl/serial_rx_ctr.sv
// Loadable bit counter; last flags the position of the final bit of a word.
module serial_rx_ctr #(
    parameter int CW   = 6,
    parameter int TERM = 36
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= CW'(1);
        else if (clr)  count <= '0;
        else if (inc)  count <= count + 1'b1;
    end

    assign last = (count == CW'(TERM - 1));
endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with output holding register and sticky errors.
// Define SERIAL_WORD_RX_PARITY_EN to add a trailing odd-parity bit and parity_err.
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = WORD36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shen,
    input  logic             sin,
    input  logic             frame,
    input  logic             lsbf,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
`ifdef SERIAL_WORD_RX_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             clr_err
);
`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB + 1);

    tRxState          state;
    logic [WIDTH-1:0] shreg, ins;
    logic             lsbf_q, last;
    logic [CW-1:0]    count;
    logic             start, shifting, complete, dir;
    int               idx, pos;

    assign start    = shen & frame;
    assign shifting = (state == SHIFT) & shen & ~frame;
    assign complete = shifting & last;
    assign busy     = (state == SHIFT);

    serial_rx_ctr #(.CW(CW), .TERM(NB)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .inc   (shifting & ~last),
        .clr   (complete),
        .count (count),
        .last  (last)
    );

    // A frame bit always starts from an empty register; the parity bit (idx==WIDTH) is not stored.
    always_comb begin
        dir = start ? lsbf : lsbf_q;
        idx = start ? 0 : int'(count);
        pos = dir ? idx : WIDTH - 1 - idx;
        ins = start ? '0 : shreg;
        for (int i = 0; i < WIDTH; i++)
            if (i == pos && idx < WIDTH) ins[i] = sin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            lsbf_q     <= 1'b0;
            word       <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (start) begin
                state  <= SHIFT;
                shreg  <= ins;
                lsbf_q <= lsbf;
            end else if (shifting) begin
                shreg <= ins;
                if (last) state <= IDLE;
            end

            if (complete && (!valid || ready)) begin
                word  <= ins;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            // A new error in the same cycle as clr_err keeps the flag set.
            overrun    <= (complete & valid & ~ready) | (overrun & ~clr_err);
            frame_err  <= (start & (state == SHIFT)) | (frame_err & ~clr_err);
`ifdef SERIAL_WORD_RX_PARITY_EN
            parity_err <= (complete & ~(^{shreg, sin})) | (parity_err & ~clr_err);
`endif
        end
    end
endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: expected words queued at stimulus, popped on valid&ready.
module tb_serial_word_rx;
    localparam int W = 36;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         shen = 1'b0, sin = 1'b0, frame = 1'b0, lsbf = 1'b0;
    logic         ready = 1'b1, clr_err = 1'b0;
    logic [W-1:0] word;
    logic         valid, busy, overrun, frame_err;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic         parity_err;
`endif

    int passed = 0;
    int total  = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .shen      (shen),
        .sin       (sin),
        .frame     (frame),
        .lsbf      (lsbf),
        .word      (word),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
`ifdef SERIAL_WORD_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .clr_err   (clr_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every accepted word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept: unexpected word %0h", word);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (word === e) passed++;
                else $display("FAIL accept: got %0h, expected %0h", word, e);
            end
        end
    end

    task automatic send_bit(input logic b, input logic fr, input logic lf);
        shen = 1'b1; sin = b; frame = fr; lsbf = lf;
        @(posedge clk); #1;
        shen = 1'b0; frame = 1'b0;
    endtask

    task automatic send_stream(input logic [W-1:0] w, input int n, input logic lf, input logic with_frame);
        for (int i = 0; i < n; i++)
            send_bit(lf ? w[i] : w[W-1-i], with_frame && (i == 0), lf);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic lf);
        send_stream(w, W, lf, 1'b1);
`ifdef SERIAL_WORD_RX_PARITY_EN
        send_bit(~(^w), 1'b0, lf);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr;
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
    endtask

    initial begin
        idle(2);
        check("rst_valid", valid, 0);
        check("rst_word", word, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {overrun, frame_err}, 0);
        rst_n = 1'b1;
        idle(1);

        // MSB-first word, valid for exactly one cycle with ready high
        exp_q.push_back(36'o123456701234);
        send_word(36'o123456701234, 1'b0);
        check("valid_after_last", valid, 1);
        check("busy_after_last", busy, 0);
        idle(1);
        check("valid_one_cycle", valid, 0);

        // Same stream, opposite bit order
        exp_q.push_back(36'h1);
        send_word(36'h1, 1'b1);
        exp_q.push_back(36'h8_0000_0000);
        send_word(36'h8_0000_0000, 1'b0);
        idle(1);

        // Overrun: second word discarded while the first is held
        ready = 1'b0;
        exp_q.push_back(36'o1);
        send_word(36'o1, 1'b0);
        send_word(36'o2, 1'b0);
        check("ovr_flag", overrun, 1);
        check("ovr_word_held", word, 36'o1);
        pulse_clr();
        check("ovr_cleared", overrun, 0);
        ready = 1'b1;
        idle(1);
        check("ovr_drained", valid, 0);

        // Frame re-asserted mid-word restarts reception
        send_stream(36'hF_FFFF_FFFF, 10, 1'b0, 1'b1);
        check("partial_busy", busy, 1);
        check("partial_no_ferr", frame_err, 0);
        exp_q.push_back(36'hA_5A5A_5A5A);
        send_word(36'hA_5A5A_5A5A, 1'b0);
        check("ferr_set", frame_err, 1);
        idle(1);
        pulse_clr();
        check("ferr_cleared", frame_err, 0);

        // Reset mid-word with a held word
        ready = 1'b0;
        send_word(36'o777, 1'b0);
        check("held_valid", valid, 1);
        check("held_word", word, 36'o777);
        send_stream(36'h1_2345_6789, 20, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_word", word, 0);
        check("async_rst_busy", busy, 0);
        idle(1);
        rst_n = 1'b1;
        ready = 1'b1;
        send_stream(36'hF_FFFF_FFFF, W, 1'b0, 1'b0);
        idle(3);
        check("noframe_valid", valid, 0);
        check("noframe_busy", busy, 0);

`ifdef SERIAL_WORD_RX_PARITY_EN
        // Odd parity: zero word with parity 0 is an error but still delivered
        exp_q.push_back(36'o0);
        send_stream(36'o0, W, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        check("par_err_set", parity_err, 1);
        check("par_word", word, 0);
        idle(1);
        pulse_clr();
        check("par_err_cleared", parity_err, 0);
        exp_q.push_back(36'o0);
        send_stream(36'o0, W, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        check("par_ok", parity_err, 0);
        idle(1);
`endif

        idle(2);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
